alu_mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_div_iter.sv | 48 ++++
 rtl/alu_mdu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mdu_pkg                                                      |
// | Description : Shared definitions for the multiply/divide sequencer:        |
// |               operation encodings, FSM state type, default datapath width  |
// |               and iteration-counter width.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mdu_pkg;

    localparam int MDU_DATA_W = 32;
    localparam int MDU_CNT_W  = $clog2(MDU_DATA_W);

    // mdu_op encodings; 3'b11x is a no-op
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Signed variants operate on magnitudes and correct the sign afterwards.
    function automatic logic mdu_op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_div_iter                                                 |
// | Description : One restoring-divide step. Shifts the next dividend bit into |
// |               the partial remainder, trial-subtracts the divisor over      |
// |               DATA_W+1 bits and produces the next remainder/quotient.      |
// |               Only compiled when MDU_DIV_EN is defined.                    |
// | Ports       : i_rem     - partial remainder                                |
// |               i_quo     - dividend bits still to shift / quotient so far   |
// |               i_divisor - divisor magnitude                                |
// |               o_rem     - next partial remainder                           |
// |               o_quo     - next quotient/dividend shift register            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`ifdef MDU_DIV_EN
module mdu_div_iter #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_trial;
    logic            w_borrow;

    assign w_shifted = {i_rem, i_quo[DATA_W-1]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*divisor: the top bit of the 33-bit difference is exactly the
    // borrow. With a zero divisor the result is discarded later anyway.
    assign w_borrow  = w_trial[DATA_W];

    always_comb begin
        o_rem = w_trial[DATA_W-1:0];
        o_quo = {i_quo[DATA_W-2:0], 1'b1};
        if (w_borrow) begin
            o_rem = w_shifted[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b0};
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mdu_ctrl                                                 |
// | Description : Multi-cycle multiply/divide sequencer owning HI/LO. Runs a   |
// |               shift-add multiplier or restoring divider for DATA_W cycles, |
// |               fixes signs, writes HI/LO and pulses done. Stalls the        |
// |               pipeline while busy; cancel flushes an in-flight operation.  |
// |               Divider present only when MDU_DIV_EN is defined; otherwise   |
// |               DIV/DIVU behave as no-ops.                                   |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               mdu_start, mdu_op, mdu_in_a, mdu_in_b, mdu_cancel  (in)      |
// |               mdu_busy, mdu_stall, mdu_done, mdu_out_hi, mdu_out_lo (out)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdu_start,
    input  logic [2:0]        mdu_op,
    input  logic [DATA_W-1:0] mdu_in_a,
    input  logic [DATA_W-1:0] mdu_in_b,
    input  logic              mdu_cancel,
    output logic              mdu_busy,
    output logic              mdu_stall,
    output logic              mdu_done,
    output logic [DATA_W-1:0] mdu_out_hi,
    output logic [DATA_W-1:0] mdu_out_lo
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mdu_state_t          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [2*DATA_W-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [DATA_W-1:0]   r_m;        // multiplicand (mul) or divisor (div) magnitude
    logic [DATA_W-1:0]   r_a_raw;    // original rs, returned in HI on divide by zero
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_div0;
    logic                r_busy;
    logic                r_done;

    logic                w_is_div_op;
    logic                w_is_muldiv;
    logic                w_signed_op;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [2*DATA_W-1:0] w_div_next;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

`ifdef MDU_DIV_EN
    logic [DATA_W-1:0] w_div_rem;
    logic [DATA_W-1:0] w_div_quo;

    mdu_div_iter #(
        .DATA_W (DATA_W)
    ) u_div_iter (
        .i_rem     (r_acc[2*DATA_W-1:DATA_W]),
        .i_quo     (r_acc[DATA_W-1:0]),
        .i_divisor (r_m),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_div_next  = {w_div_rem, w_div_quo};
    assign w_is_div_op = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
`else
    assign w_div_next  = r_acc;
    assign w_is_div_op = 1'b0;
`endif

    assign w_is_muldiv = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) || w_is_div_op;
    assign w_signed_op = mdu_op_is_signed(mdu_op);
    assign w_mag_a     = (w_signed_op && mdu_in_a[DATA_W-1]) ? -mdu_in_a : mdu_in_a;
    assign w_mag_b     = (w_signed_op && mdu_in_b[DATA_W-1]) ? -mdu_in_b : mdu_in_b;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole 65-bit value right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_a_raw   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mdu_start) begin
                        if (w_is_muldiv) begin
                            r_is_div  <= w_is_div_op;
                            r_m       <= w_is_div_op ? w_mag_b : w_mag_a;
                            r_acc     <= {{DATA_W{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
                            r_a_raw   <= mdu_in_a;
                            r_neg_res <= w_signed_op && (mdu_in_a[DATA_W-1] ^ mdu_in_b[DATA_W-1]);
                            r_neg_rem <= w_signed_op && mdu_in_a[DATA_W-1];
                            r_div0    <= w_is_div_op && (mdu_in_b == '0);
                            r_count   <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= CALC;
                        end else if (mdu_op == MDU_MTHI) begin
                            r_hi <= mdu_in_a;
                        end else if (mdu_op == MDU_MTLO) begin
                            r_lo <= mdu_in_a;
                        end
                    end
                end
                CALC: begin
                    if (mdu_cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_CNT) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    r_busy <= 1'b0;
                    if (mdu_cancel) begin
                        r_state <= IDLE;
                    end else begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end else if (r_div0) begin
                            r_hi <= r_a_raw;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mdu_busy   = r_busy;
    assign mdu_done   = r_done;
    assign mdu_out_hi = r_hi;
    assign mdu_out_lo = r_lo;
    assign mdu_stall  = r_busy || (mdu_start && (r_state == IDLE) && w_is_muldiv);

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_mdu_ctrl                                              |
// | Description : Directed self-checking bench for alu_mdu_ctrl: reset,        |
// |               multiply timing/results, MT writes, cancel, mid-op reset,    |
// |               start while busy/done, and divide (or divider-absent) cases. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdu_start = 1'b0;
    logic [2:0]  mdu_op = 3'b000;
    logic [31:0] mdu_in_a = '0;
    logic [31:0] mdu_in_b = '0;
    logic        mdu_cancel = 1'b0;
    logic        mdu_busy;
    logic        mdu_stall;
    logic        mdu_done;
    logic [31:0] mdu_out_hi;
    logic [31:0] mdu_out_lo;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mdu_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mdu_start  (mdu_start),
        .mdu_op     (mdu_op),
        .mdu_in_a   (mdu_in_a),
        .mdu_in_b   (mdu_in_b),
        .mdu_cancel (mdu_cancel),
        .mdu_busy   (mdu_busy),
        .mdu_stall  (mdu_stall),
        .mdu_done   (mdu_done),
        .mdu_out_hi (mdu_out_hi),
        .mdu_out_lo (mdu_out_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs must already be driven with mdu_start=1. Returns the number of
    // samples from the accepting edge up to and including the done sample,
    // and how many of those samples showed busy.
    task automatic run_op(output int cyc, output int bcnt);
        tick();
        mdu_start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (!mdu_done && cyc < 200) begin
            if (mdu_busy) bcnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (mdu_out_hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", mdu_out_hi); else n_pass++;
        n_checks++; if (mdu_out_lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", mdu_out_lo); else n_pass++;
        n_checks++; if (mdu_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mdu_busy); else n_pass++;
        n_checks++; if (mdu_done !== 1'b0) $display("FAIL reset_done: got %b want 0", mdu_done); else n_pass++;
        n_checks++; if (mdu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mdu_stall); else n_pass++;
    endtask

    task automatic test_mult();
        logic [2:0]  v_op [6] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULT, MDU_MULTU, MDU_MULTU};
        logic [31:0] v_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] v_b  [6] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFB, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] v_hi [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h40000000, 32'hFFFFFFFE, 32'h00000000};
        logic [31:0] v_lo [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0000000F, 32'h00000000, 32'h00000001, 32'h00000000};
        int cyc;
        int bcnt;
        for (int i = 0; i < 6; i++) begin
            mdu_op = v_op[i]; mdu_in_a = v_a[i]; mdu_in_b = v_b[i]; mdu_start = 1'b1;
            #1;
            n_checks++; if (mdu_stall !== 1'b1) $display("FAIL mul_stall[%0d]: got %b want 1", i, mdu_stall); else n_pass++;
            run_op(cyc, bcnt);
            n_checks++; if (cyc != 34) $display("FAIL mul_latency[%0d]: got %0d want 34", i, cyc); else n_pass++;
            if (i == 0) begin
                n_checks++; if (bcnt != 33) $display("FAIL mul_busy_cycles: got %0d want 33", bcnt); else n_pass++;
            end
            n_checks++; if (mdu_out_hi !== v_hi[i]) $display("FAIL mul_hi[%0d]: got %h want %h", i, mdu_out_hi, v_hi[i]); else n_pass++;
            n_checks++; if (mdu_out_lo !== v_lo[i]) $display("FAIL mul_lo[%0d]: got %h want %h", i, mdu_out_lo, v_lo[i]); else n_pass++;
            tick();
            if (i == 0) begin
                n_checks++; if (mdu_done !== 1'b0) $display("FAIL mul_done_pulse: got %b want 0", mdu_done); else n_pass++;
                n_checks++; if (mdu_busy !== 1'b0) $display("FAIL mul_idle_busy: got %b want 0", mdu_busy); else n_pass++;
            end
        end
    endtask

    task automatic test_mt_cancel();
        logic seen_done;
        mdu_op = MDU_MTHI; mdu_in_a = 32'h12345678; mdu_start = 1'b1;
        #1;
        n_checks++; if (mdu_stall !== 1'b0) $display("FAIL mthi_stall: got %b want 0", mdu_stall); else n_pass++;
        tick();
        mdu_start = 1'b0;
        n_checks++; if (mdu_out_hi !== 32'h12345678) $display("FAIL mthi_hi: got %h want 12345678", mdu_out_hi); else n_pass++;
        n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", mdu_busy, mdu_done); else n_pass++;
        mdu_op = MDU_MTLO; mdu_in_a = 32'h0; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        n_checks++; if (mdu_out_lo !== 32'h0) $display("FAIL mtlo_lo: got %h want 0", mdu_out_lo); else n_pass++;

        mdu_op = MDU_MULTU; mdu_in_a = 32'd3; mdu_in_b = 32'd4; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 5) begin
                mdu_op = MDU_MTHI; mdu_in_a = 32'hDEADBEEF; mdu_start = 1'b1;
                #1;
                n_checks++; if (mdu_stall !== 1'b1) $display("FAIL busy_stall: got %b want 1", mdu_stall); else n_pass++;
            end
            tick();
            mdu_start = 1'b0;
        end
        n_checks++; if (mdu_busy !== 1'b1) $display("FAIL calc10_busy: got %b want 1", mdu_busy); else n_pass++;
        mdu_cancel = 1'b1;
        tick();
        mdu_cancel = 1'b0;
        n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) $display("FAIL cancel_flags: got busy=%b done=%b want 0 0", mdu_busy, mdu_done); else n_pass++;
        n_checks++; if (mdu_out_hi !== 32'h12345678) $display("FAIL cancel_hi: got %h want 12345678", mdu_out_hi); else n_pass++;
        n_checks++; if (mdu_out_lo !== 32'h0) $display("FAIL cancel_lo: got %h want 0", mdu_out_lo); else n_pass++;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (mdu_done) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) $display("FAIL cancel_no_done: got %b want 0", seen_done); else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic seen_done;
        mdu_op = MDU_MULTU; mdu_in_a = 32'hFFFFFFFF; mdu_in_b = 32'hFFFFFFFF; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1; mdu_start = 1'b1; mdu_cancel = 1'b1;
        tick();
        rst = 1'b0; mdu_start = 1'b0; mdu_cancel = 1'b0;
        n_checks++; if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) $display("FAIL rst_mid_flags: got busy=%b done=%b want 0 0", mdu_busy, mdu_done); else n_pass++;
        n_checks++; if (mdu_out_hi !== 32'h0) $display("FAIL rst_mid_hi: got %h want 0", mdu_out_hi); else n_pass++;
        n_checks++; if (mdu_out_lo !== 32'h0) $display("FAIL rst_mid_lo: got %h want 0", mdu_out_lo); else n_pass++;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (mdu_done || mdu_busy) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) $display("FAIL rst_mid_quiet: got %b want 0", seen_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bcnt;
        mdu_op = MDU_MULTU; mdu_in_a = 32'd3; mdu_in_b = 32'd4; mdu_start = 1'b1;
        run_op(cyc, bcnt);
        n_checks++; if (cyc != 34) $display("FAIL b2b_latency0: got %0d want 34", cyc); else n_pass++;
        // start arriving while in DONE must be dropped
        mdu_op = MDU_MTHI; mdu_in_a = 32'hCAFEF00D; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        n_checks++; if (mdu_out_hi !== 32'h0) $display("FAIL done_start_hi: got %h want 0", mdu_out_hi); else n_pass++;
        n_checks++; if (mdu_out_lo !== 32'd12) $display("FAIL b2b_lo0: got %h want 0000000c", mdu_out_lo); else n_pass++;
        mdu_op = MDU_MULT; mdu_in_a = 32'hFFFFFFFD; mdu_in_b = 32'hFFFFFFFB; mdu_start = 1'b1;
        run_op(cyc, bcnt);
        n_checks++; if (cyc != 34) $display("FAIL b2b_latency1: got %0d want 34", cyc); else n_pass++;
        n_checks++; if (mdu_out_lo !== 32'd15) $display("FAIL b2b_lo1: got %h want 0000000f", mdu_out_lo); else n_pass++;
        tick();
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        logic [2:0]  v_op [7] = '{MDU_DIV, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV};
        logic [31:0] v_a  [7] = '{32'hFFFFFFF9, 32'h80000000, 32'h00000005, 32'hFFFFFFF9, 32'd100, 32'hFFFFFFFF, 32'd7};
        logic [31:0] v_b  [7] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'd7, 32'h00000010, 32'hFFFFFFFE};
        logic [31:0] v_hi [7] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'hFFFFFFF9, 32'd2, 32'h0000000F, 32'd1};
        logic [31:0] v_lo [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd14, 32'h0FFFFFFF, 32'hFFFFFFFD};
        int cyc;
        int bcnt;
        for (int i = 0; i < 7; i++) begin
            mdu_op = v_op[i]; mdu_in_a = v_a[i]; mdu_in_b = v_b[i]; mdu_start = 1'b1;
            #1;
            n_checks++; if (mdu_stall !== 1'b1) $display("FAIL div_stall[%0d]: got %b want 1", i, mdu_stall); else n_pass++;
            run_op(cyc, bcnt);
            n_checks++; if (cyc != 34 || bcnt != 33) $display("FAIL div_latency[%0d]: got %0d/%0d want 34/33", i, cyc, bcnt); else n_pass++;
            n_checks++; if (mdu_out_hi !== v_hi[i]) $display("FAIL div_hi[%0d]: got %h want %h", i, mdu_out_hi, v_hi[i]); else n_pass++;
            n_checks++; if (mdu_out_lo !== v_lo[i]) $display("FAIL div_lo[%0d]: got %h want %h", i, mdu_out_lo, v_lo[i]); else n_pass++;
            tick();
        end
    endtask
`else
    // Without the divider, DIV/DIVU and 11x must be ignored entirely.
    task automatic test_nodiv();
        logic [2:0] v_op [3] = '{MDU_DIV, MDU_DIVU, 3'b110};
        for (int i = 0; i < 3; i++) begin
            mdu_op = v_op[i]; mdu_in_a = 32'd7; mdu_in_b = 32'd2; mdu_start = 1'b1;
            #1;
            n_checks++; if (mdu_stall !== 1'b0) $display("FAIL nodiv_stall[%0d]: got %b want 0", i, mdu_stall); else n_pass++;
            tick();
            mdu_start = 1'b0;
            n_checks++; if (mdu_busy !== 1'b0) $display("FAIL nodiv_busy[%0d]: got %b want 0", i, mdu_busy); else n_pass++;
            tick();
            n_checks++; if (mdu_done !== 1'b0) $display("FAIL nodiv_done[%0d]: got %b want 0", i, mdu_done); else n_pass++;
            n_checks++; if (mdu_out_hi !== 32'h0 || mdu_out_lo !== 32'd15)
                $display("FAIL nodiv_hilo[%0d]: got %h_%h want 00000000_0000000f", i, mdu_out_hi, mdu_out_lo);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_mt_cancel();
        test_rst_mid();
        test_back_to_back();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
